// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and the
// request fault check used at acceptance time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_MEM_WORDS = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_t;

    // Misalignment, illegal width encoding (BU/HU are load-only) or word index past the memory.
    function automatic logic is_fault(input logic        we,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input int unsigned mem_words = LSU_MEM_WORDS);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr[0];
            F3_W:    bad = |addr[1:0];
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= mem_words) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane steering: extends load data out of a memory word and merges store data into one.
// Purely combinational, no latency, no flow control.
// Backpressure: none.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  a,
                                            input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [31:0] wd,
                                          input logic [1:0]  a,
                                          input logic [2:0]  f3);
        logic [31:0] r;
        r = w;
        case (f3)
            F3_B:    r[{a, 3'b000} +: 8]     = wd[7:0];
            F3_H:    r[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign load_data  = extract(word, addr_lo, funct3);
    assign store_word = merge(word, wdata, addr_lo, funct3);

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data memory with combinational read.
// Latency accept->resp: fault 1, load 2, SW 2, SB/SH 3 (read-modify-write).
// Backpressure: req_ready only in IDLE; one request in flight, responses cannot be stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_nxt;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        req_bad;
    logic [31:0] lane_load;
    logic [31:0] lane_store;

    assign req_bad = is_fault(req_we, req_funct3, req_addr, MEM_WORDS);

    lsu_lane u_lane (
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad)                 state_nxt = ST_RESP;
                    else if (!req_we)            state_nxt = ST_LOAD;
                    else if (req_funct3 == F3_W) state_nxt = ST_WRITE;
                    else                         state_nxt = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_nxt = ST_RESP;
            ST_RMW_RD: state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Response registers only change on the edge entering RESP, so they hold between responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_we) merge_q <= req_wdata;
                        if (req_bad) begin
                            rdata_q <= 32'h0;
                            fault_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q <= lane_load;
                    fault_q <= 1'b0;
                end
                ST_RMW_RD: merge_q <= lane_store;
                ST_WRITE: begin
                    rdata_q <= 32'h0;
                    fault_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = rst && (state == ST_IDLE);
    assign resp_valid = rst && (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = merge_q;
    assign mem_we     = rst && we_q && (state == ST_WRITE);

endmodule
